// File: rtl/multi_channel_rate_limiter_pkg.sv
// Shared widths, default step constants and FSM encoding for the rate limiter.
// The optional idle snap feature is enabled with RATE_LIMITER_IDLE_SNAP_EN.
package multi_channel_rate_limiter_pkg;

  localparam int unsigned REC_VAL_BIT_WIDTH      = 8;
  localparam int unsigned RATE_BIT_WIDTH         = 16;
  localparam int unsigned DEFAULT_AVG_LOG2       = 3;
  localparam int unsigned DEFAULT_MAX_STEP_UP    = 4;
  localparam int unsigned DEFAULT_MAX_STEP_DOWN  = 8;
  localparam int unsigned DEFAULT_IDLE_THRESHOLD = 5;

  typedef enum logic [1:0] {
    LimIdle  = 2'd0,
    LimLatch = 2'd1,
    LimProc  = 2'd2,
    LimDone  = 2'd3
  } lim_state_e;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_rate_limiter_slew_step_clamp.sv
// Combinational asymmetric slew clamp: moves out_cur toward avg by at most
// MAX_STEP_UP upward or MAX_STEP_DOWN downward, never past avg.
module slew_step_clamp
  import multi_channel_rate_limiter_pkg::*;
#(
  parameter int unsigned OUT_WIDTH     = RATE_BIT_WIDTH,
  parameter int unsigned MAX_STEP_UP   = DEFAULT_MAX_STEP_UP,
  parameter int unsigned MAX_STEP_DOWN = DEFAULT_MAX_STEP_DOWN
) (
  input  logic [OUT_WIDTH-1:0] avg,
  input  logic [OUT_WIDTH-1:0] out_cur,
  output logic [OUT_WIDTH-1:0] out_next
);

  localparam logic signed [OUT_WIDTH:0] StepUp   = (OUT_WIDTH+1)'(MAX_STEP_UP);
  localparam logic signed [OUT_WIDTH:0] StepDown = (OUT_WIDTH+1)'(MAX_STEP_DOWN);

  logic signed [OUT_WIDTH:0] delta;
  logic signed [OUT_WIDTH:0] step;

  always_comb begin
    delta = $signed({1'b0, avg}) - $signed({1'b0, out_cur});
    if (delta > StepUp) begin
      step = StepUp;
    end else if (delta < -StepDown) begin
      step = -StepDown;
    end else begin
      step = delta;
    end
    out_next = out_cur + step[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/multi_channel_rate_limiter.sv
// Time-multiplexed moving-average plus slew limiter for NUM_CH receiver channels.
// Define RATE_LIMITER_IDLE_SNAP_EN to snap a channel to zero on low samples.
module multi_channel_rate_limiter
  import multi_channel_rate_limiter_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned IN_WIDTH       = REC_VAL_BIT_WIDTH,
  parameter int unsigned OUT_WIDTH      = RATE_BIT_WIDTH,
  parameter int unsigned AVG_LOG2       = DEFAULT_AVG_LOG2,
  parameter int unsigned MAX_STEP_UP    = DEFAULT_MAX_STEP_UP,
  parameter int unsigned MAX_STEP_DOWN  = DEFAULT_MAX_STEP_DOWN,
  parameter int unsigned IDLE_THRESHOLD = DEFAULT_IDLE_THRESHOLD
) (
  input  logic                        us_clk,
  input  logic                        reset,
  input  logic                        start_signal,
  input  logic [NUM_CH*IN_WIDTH-1:0]  value_in,
  output logic [NUM_CH*OUT_WIDTH-1:0] value_out,
  output logic                        active_signal,
  output logic                        complete_signal
);

  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = IN_WIDTH + AVG_LOG2;
  localparam int unsigned ChW   = idx_width(NUM_CH);

  if (OUT_WIDTH < IN_WIDTH + 1 || IDLE_THRESHOLD >= (1 << IN_WIDTH)) begin : g_bad_cfg
    $error("multi_channel_rate_limiter: illegal width or threshold configuration");
  end

  lim_state_e state_q, state_d;

  logic [ChW-1:0]      ch_idx_q;
  logic [AVG_LOG2-1:0] wptr_q;
  logic [IN_WIDTH-1:0] shadow_q [NUM_CH];
  logic [IN_WIDTH-1:0] hist_q   [NUM_CH][Depth];
  logic [SumW-1:0]     sum_q    [NUM_CH];
  logic [OUT_WIDTH-1:0] out_q   [NUM_CH];

  logic [IN_WIDTH-1:0]  sample;
  logic [IN_WIDTH-1:0]  oldest;
  logic [SumW-1:0]      sum_nxt;
  logic [OUT_WIDTH-1:0] avg_ext;
  logic [OUT_WIDTH-1:0] out_cur;
  logic [OUT_WIDTH-1:0] out_nxt;
  logic                 last_ch;
  logic                 snap;

  // Shared datapath for the channel selected by ch_idx_q.
  always_comb begin
    sample  = shadow_q[ch_idx_q];
    oldest  = hist_q[ch_idx_q][wptr_q];
    out_cur = out_q[ch_idx_q];
    sum_nxt = sum_q[ch_idx_q] + SumW'(sample) - SumW'(oldest);
    avg_ext = OUT_WIDTH'(sum_nxt >> AVG_LOG2);
    last_ch = (ch_idx_q == ChW'(NUM_CH - 1));
`ifdef RATE_LIMITER_IDLE_SNAP_EN
    snap    = (sample <= IN_WIDTH'(IDLE_THRESHOLD));
`else
    snap    = 1'b0;
`endif
  end

  slew_step_clamp #(
    .OUT_WIDTH    (OUT_WIDTH),
    .MAX_STEP_UP  (MAX_STEP_UP),
    .MAX_STEP_DOWN(MAX_STEP_DOWN)
  ) u_clamp (
    .avg     (avg_ext),
    .out_cur (out_cur),
    .out_next(out_nxt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LimIdle:  if (start_signal) state_d = LimLatch;
      LimLatch: state_d = LimProc;
      LimProc:  if (last_ch) state_d = LimDone;
      LimDone:  state_d = LimIdle;
      default:  state_d = LimIdle;
    endcase
  end

  always_comb begin
    active_signal   = (state_q != LimIdle);
    complete_signal = (state_q == LimDone);
  end

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state_q <= LimIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      ch_idx_q <= '0;
      wptr_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_q[c] <= '0;
        sum_q[c]    <= '0;
        out_q[c]    <= '0;
        for (int d = 0; d < Depth; d++) begin
          hist_q[c][d] <= '0;
        end
      end
    end else begin
      case (state_q)
        LimLatch: begin
          for (int c = 0; c < NUM_CH; c++) begin
            shadow_q[c] <= value_in[c*IN_WIDTH +: IN_WIDTH];
          end
          ch_idx_q <= '0;
        end
        LimProc: begin
          if (snap) begin
            for (int d = 0; d < Depth; d++) begin
              hist_q[ch_idx_q][d] <= '0;
            end
            sum_q[ch_idx_q] <= '0;
            out_q[ch_idx_q] <= '0;
          end else begin
            hist_q[ch_idx_q][wptr_q] <= sample;
            sum_q[ch_idx_q]          <= sum_nxt;
            out_q[ch_idx_q]          <= out_nxt;
          end
          if (!last_ch) ch_idx_q <= ch_idx_q + 1'b1;
        end
        LimDone: wptr_q <= wptr_q + 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign value_out[k*OUT_WIDTH +: OUT_WIDTH] = out_q[k];
  end

endmodule
